// File: rtl/project_pwm_trip_zone.sv
// Trip-zone protection between the deadband outputs and the PWM pins.
// A filtered fault pin or a software force overrides the PWM lines with a safe level.
module project_pwm_trip_zone #(
  parameter int CHANNELS = 6
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [CHANNELS-1:0] i_pwm,
  input  logic                i_trip_n,
  input  logic                i_period_zero,
  input  logic [7:0]          i_cfg,
  input  logic                i_force,
  input  logic                i_clear,
  output logic [CHANNELS-1:0] o_pwm,
  output logic                o_tripped,
  output logic                o_trip_flag
);

  // state    | meaning
  // ARMED    | no trip, PWM passes through
  // CBC_TRIP | tripped, released at the next clean period-zero sync
  // OST_TRIP | tripped, released only by an explicit clear with the pin high
  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CBC_TRIP = 2'd1,
    OST_TRIP = 2'd2
  } state_t;

  state_t      state, next_state;
  logic        en, mode_cbc;
  logic [1:0]  action;
  logic [3:0]  filt_n;
  logic        s1, s2;
  logic [3:0]  cnt;
  logic        det, trip;

  assign en       = i_cfg[0];
  assign mode_cbc = i_cfg[1];
  assign action   = i_cfg[3:2];
  assign filt_n   = i_cfg[7:4];

  assign det  = en & ~s2 & (cnt >= filt_n);
  assign trip = det | (en & i_force);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= ARMED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = ARMED;
    end else begin
      unique case (state)
        ARMED: begin
          if (trip) next_state = mode_cbc ? CBC_TRIP : OST_TRIP;
        end
        CBC_TRIP: begin
          if (i_period_zero && s2 && !trip) next_state = ARMED;
        end
        OST_TRIP: begin
          if (i_clear && s2 && !trip) next_state = ARMED;
        end
        default: next_state = ARMED;
      endcase
    end
  end

  // Two-flop synchronizer on the asynchronous fault pin, then the low-run filter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      cnt <= 4'd0;
    end else begin
      s1 <= i_trip_n;
      s2 <= s1;
      if (!en || s2) begin
        cnt <= 4'd0;
      end else if (cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_pwm       <= '0;
      o_tripped   <= 1'b0;
      o_trip_flag <= 1'b0;
    end else begin
      o_tripped <= (next_state != ARMED);
      if (trip) begin
        o_trip_flag <= 1'b1;
      end else if (i_clear) begin
        o_trip_flag <= 1'b0;
      end
      // Hold-last keeps whatever was on the pins when the trip began.
      if (next_state == ARMED) begin
        o_pwm <= i_pwm;
      end else begin
        unique case (action)
          2'b00:   o_pwm <= '0;
          2'b01:   o_pwm <= '1;
          2'b10:   o_pwm <= o_pwm;
          default: o_pwm <= i_pwm;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_project_pwm_trip_zone.sv
// Bench for project_pwm_trip_zone: directed scenarios plus random traffic,
// checked by a queue-based scoreboard fed from a behavioural model.
module tb_project_pwm_trip_zone;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] pwm_in = '0;
  logic       trip_n = 1'b1;
  logic       pz = 1'b0;
  logic [7:0] cfg = '0;
  logic       frc = 1'b0;
  logic       clr = 1'b0;
  logic [5:0] pwm_out;
  logic       tripped;
  logic       flag;

  always #5 clk = ~clk;

  project_pwm_trip_zone #(.CHANNELS(6)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pwm(pwm_in), .i_trip_n(trip_n),
    .i_period_zero(pz), .i_cfg(cfg), .i_force(frc), .i_clear(clr),
    .o_pwm(pwm_out), .o_tripped(tripped), .o_trip_flag(flag)
  );

  typedef struct {
    logic [5:0] pwm;
    logic       tr;
    logic       fl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model: pin history, length of the current low run, a tripped bit
  // with the mode captured at trip entry, and the sticky flag.
  bit         m_s1 = 1'b1, m_s2 = 1'b1;
  int         lowrun = 0;
  bit         m_trip = 1'b0, m_cbc = 1'b0;
  logic [5:0] m_pwm = '0;
  bit         m_flag = 1'b0;

  task automatic model_edge();
    bit en, det, trp;
    int n;
    logic [1:0] act;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; lowrun = 0;
      m_trip = 1'b0; m_pwm = '0; m_flag = 1'b0;
    end else begin
      en  = cfg[0];
      n   = int'(cfg[7:4]);
      act = cfg[3:2];
      det = en && !m_s2 && (lowrun >= n);
      trp = det || (en && frc);
      if (!en) m_trip = 1'b0;
      else if (!m_trip) begin
        if (trp) begin m_trip = 1'b1; m_cbc = cfg[1]; end
      end else if (!trp && m_s2 && (m_cbc ? pz : clr)) m_trip = 1'b0;
      if (!m_trip) m_pwm = pwm_in;
      else if (act == 2'd0) m_pwm = 6'h00;
      else if (act == 2'd1) m_pwm = 6'h3F;
      else if (act == 2'd3) m_pwm = pwm_in;
      if (trp) m_flag = 1'b1;
      else if (clr) m_flag = 1'b0;
      lowrun = (en && !m_s2) ? ((lowrun < 15) ? lowrun + 1 : 15) : 0;
      m_s2 = m_s1;
      m_s1 = trip_n;
    end
    q.push_back('{pwm: m_pwm, tr: m_trip, fl: m_flag});
  endtask

  // Inputs change at the falling edge; the model predicts the result of the next rising edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [5:0] p, input logic t, input logic f);
    checks++;
    if (pwm_out !== p || tripped !== t || flag !== f) begin
      failures++;
      $display("FAIL %s: got pwm=%h tripped=%b flag=%b, want pwm=%h tripped=%b flag=%b",
               name, pwm_out, tripped, flag, p, t, f);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (pwm_out !== e.pwm || tripped !== e.tr || flag !== e.fl) begin
          failures++;
          $display("FAIL scoreboard @%0t: got pwm=%h tripped=%b flag=%b, want pwm=%h tripped=%b flag=%b",
                   $time, pwm_out, tripped, flag, e.pwm, e.tr, e.fl);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : driver
    @(negedge clk);
    rst_n = 1'b0;
    ticks(2);
    chk("reset", 6'h00, 1'b0, 1'b0);

    rst_n = 1'b1; cfg = 8'h01; pwm_in = 6'h2A;
    tick();
    chk("pass_through", 6'h2A, 1'b0, 1'b0);

    cfg = 8'h31;
    trip_n = 1'b0; ticks(3);
    trip_n = 1'b1; ticks(5);
    chk("filter_short_pulse", 6'h2A, 1'b0, 1'b0);
    trip_n = 1'b0; ticks(5);
    chk("filter_edge_k4", 6'h2A, 1'b0, 1'b0);
    tick();
    chk("filter_trip_k5", 6'h00, 1'b1, 1'b1);
    trip_n = 1'b1; ticks(2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ost_release_after_filter", 6'h2A, 1'b0, 1'b0);

    cfg = 8'h07; pwm_in = 6'h11;
    trip_n = 1'b0; ticks(3);
    chk("cbc_trip_high", 6'h3F, 1'b1, 1'b1);
    pz = 1'b1; tick(); pz = 1'b0;
    chk("cbc_pz_pin_low", 6'h3F, 1'b1, 1'b1);
    trip_n = 1'b1; ticks(3);
    pz = 1'b1; tick(); pz = 1'b0;
    chk("cbc_release", 6'h11, 1'b0, 1'b1);

    clr = 1'b1; tick(); clr = 1'b0;
    cfg = 8'h01;
    frc = 1'b1; tick(); frc = 1'b0;
    chk("ost_force", 6'h00, 1'b1, 1'b1);
    pz = 1'b1; ticks(2); pz = 1'b0;
    chk("ost_pz_ignored", 6'h00, 1'b1, 1'b1);
    trip_n = 1'b0; ticks(3);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ost_clear_pin_low", 6'h00, 1'b1, 1'b1);
    trip_n = 1'b1; ticks(3);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ost_clear_release", 6'h11, 1'b0, 1'b0);

    cfg = 8'h09; pwm_in = 6'h15; tick();
    frc = 1'b1; tick(); frc = 1'b0;
    chk("hold_entry", 6'h15, 1'b1, 1'b1);
    pwm_in = 6'h2A; tick();
    chk("hold_toggle1", 6'h15, 1'b1, 1'b1);
    pwm_in = 6'h0A; tick();
    chk("hold_toggle2", 6'h15, 1'b1, 1'b1);
    frc = 1'b1; clr = 1'b1; tick(); frc = 1'b0; clr = 1'b0;
    chk("force_clear_priority", 6'h15, 1'b1, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("hold_release", 6'h0A, 1'b0, 1'b0);

    cfg = 8'h01;
    frc = 1'b1; tick(); frc = 1'b0;
    cfg = 8'h00; pwm_in = 6'h33; tick();
    chk("disable_mid_trip", 6'h33, 1'b0, 1'b1);
    cfg = 8'h01;
    frc = 1'b1; tick(); frc = 1'b0;
    chk("retrip", 6'h00, 1'b1, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("reset_mid_trip", 6'h00, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg = 8'($urandom);
        cfg[0] = ($urandom_range(0, 7) != 0);
        cfg[7:4] = 4'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 7) == 0) trip_n = ~trip_n;
      pwm_in = 6'($urandom);
      frc    = ($urandom_range(0, 39) == 0);
      clr    = ($urandom_range(0, 9) == 0);
      pz     = ($urandom_range(0, 7) == 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; frc = 1'b0; clr = 1'b0; pz = 1'b0;
    ticks(2);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/project_pwm_trip_zone.md
# project_pwm_trip_zone

Trip-zone protection stage inserted between the six deadband outputs and the `uo_out[5:0]` pins of the PWM peripheral. It watches an external active-low fault pin (`ui_in[1]`) and a software force strobe. On a fault it overrides all six PWM outputs with a configured safe level. Release is either cycle-by-cycle, at the next period-zero sync, or one-shot, requiring an explicit clear. `o_tripped` drives `uo_out[6]`; configuration comes from one new register-file byte.

## Interface
- `CHANNELS`, default 6: number of PWM lines passed through.
- `i_clk`  in  1: single system clock.
- `i_reset_n`  in  1: reset, synchronous, active-low.
- `i_pwm`  in  CHANNELS: deadband outputs, in the `clk` domain.
- `i_trip_n`  in  1: external fault pin, active-low, asynchronous to `i_clk`.
- `i_period_zero`  in  1: one-cycle pulse from the period counter at count zero.
- `i_cfg`  in  8: configuration byte.
  - [0] enable.
  - [1] mode: 0 = one-shot (OST), 1 = cycle-by-cycle (CBC).
  - [3:2] action: 00 force low, 01 force high, 10 hold last, 11 flag only.
  - [7:4] filter length N.
- `i_force`  in  1: software trip pulse.
- `i_clear`  in  1: software clear pulse; releases OST and clears the sticky flag.
- `o_pwm`  out  CHANNELS: protected PWM, registered.
- `o_tripped`  out  1: state != ARMED, registered.
- `o_trip_flag`  out  1: sticky trip indicator.

## Operation
- **Synchronizer:** two flops `s1` and `s2` on `i_trip_n`. Both reset to 1, meaning no fault.
- **Filter counter `cnt`:** 4 bits.
  - Cleared when `s2`=1.
  - Increments, saturating at 15, while `s2`=0.
  - `det` = en & (`s2`=0) & (`cnt`>=N), so the fault must be seen low on N+1 consecutive samples.
- **Trip request:** `trip` = `det` | (en & `i_force`).
- **States:** ARMED, CBC_TRIP, OST_TRIP.
  - ARMED -> CBC_TRIP or OST_TRIP on `trip`, chosen by `i_cfg[1]` at that edge. Mode is latched into the state; a later mode write does not move a tripped state.
  - CBC_TRIP -> ARMED on `i_period_zero` & `s2`=1 & !`trip`. Otherwise it stays.
  - OST_TRIP -> ARMED on `i_clear` & `s2`=1 & !`trip`. A clear while the pin is still low is ignored.
  - en=0 forces ARMED, clears `cnt`, and passes PWM through. `o_trip_flag` is kept.
- **Output register, updated every edge from next_state:**
  - When next_state = ARMED: `o_pwm` <= `i_pwm`.
  - Tripped, action 00: all 0.
  - Tripped, action 01: all 1.
  - Tripped, action 10: `o_pwm` is not updated, so it keeps the value captured at trip entry.
  - Tripped, action 11: `o_pwm` <= `i_pwm`; only the flags indicate the trip.
  - Action is read live every cycle.
- **`o_tripped`:** registered next_state != ARMED.
- **`o_trip_flag`:**
  - Set on any edge where `trip`=1.
  - Cleared by `i_clear` only when `trip`=0 that cycle; set has priority.
- **Simultaneous events:**
  - `trip` and `i_clear` together: trip wins.
  - `trip` and `i_period_zero` in CBC_TRIP: stay tripped.
  - `i_force` during a trip: no state change; flag stays set.

## Timing
- **Reset (synchronous, `i_reset_n`=0 at an edge):** state ARMED, `s1`=`s2`=1, `cnt`=0, `o_pwm`=0, `o_tripped`=0, `o_trip_flag`=0. Reset mid-trip releases at that edge.
- **Pass-through latency:** 1 cycle (`i_pwm` at edge k appears on `o_pwm` after edge k).
- **Pin trip latency:** `i_trip_n` sampled low at edge k and held gives `o_pwm` safe and `o_tripped`=1 after edge k+2+N. A low pulse shorter than N+1 samples at `s2` causes no trip.
- **Force latency:** `i_force` sampled at edge k gives `o_pwm` safe after edge k.
- **CBC release:** at the `i_period_zero` edge, `o_pwm` <= `i_pwm` that same edge.
- **OST release:** at the `i_clear` edge, `o_pwm` <= `i_pwm` that same edge.

## Test plan
- **Reset/pass-through:** reset, cfg=0x01, drive `i_pwm`=6'h2A -> `o_pwm`=6'h2A one cycle later; `o_tripped`=0, `o_trip_flag`=0.
- **Filter:** cfg=0x31 (N=3, OST, force low).
  - `i_trip_n` low 3 cycles -> no trip.
  - Low held 4+ cycles from edge k -> `o_pwm`=0 after edge k+5, `o_tripped`=1, `o_trip_flag`=1.
- **CBC:** cfg=0x07 (N=0, CBC, force high).
  - Pin low 1 cycle -> `o_pwm`=6'h3F.
  - First `i_period_zero` while pin still low -> stays tripped.
  - Next `i_period_zero` with pin high -> `o_pwm` follows `i_pwm`, `o_tripped`=0, `o_trip_flag` still 1.
- **OST clear rules:** cfg=0x01, `i_force` pulse -> `o_pwm`=0.
  - `i_period_zero` pulses -> no release.
  - `i_clear` while pin low -> no release.
  - `i_clear` with pin high -> release; flag=0.
- **Hold and priority:** cfg=0x09 (hold), `i_pwm`=6'h15, force -> `o_pwm` frozen at 6'h15 while `i_pwm` toggles. Then `i_force` and `i_clear` in the same cycle -> stays tripped, flag=1.
- **Enable and reset mid-trip:** tripped OST, write cfg[0]=0 -> ARMED, pass-through, flag retained. Re-trip, then assert `i_reset_n`=0 for one edge -> all outputs 0, state ARMED.
